// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared definitions for the sequential shift-add multiplier:
//                FSM state encoding and default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Default operand width in bits
    localparam int DEFAULT_WIDTH = 8;

    // FSM state encoding; 2'b11 is unused and recovers to IDLE
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] CALC = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/add_n.sv
`default_nettype none
// ============================================================================
//  Module      : add_n
//  Description : 2*WIDTH-bit behavioural adder used for the accumulate step
//                of the sequential multiplier. Carry-out is discarded; the
//                unsigned product always fits in 2*WIDTH bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_n
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] i_a,
    input  logic [2*WIDTH-1:0] i_b,
    output logic [2*WIDTH-1:0] o_sum
);

    // Plain sum, left to synthesis for adder architecture selection
    assign o_sum = i_a + i_b;

endmodule : add_n
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier
//  Description : Sequential shift-add multiplier. One multiplier bit is
//                processed per clock; signed operands are handled by
//                multiplying magnitudes and negating the result when the
//                operand signs differ. Result is registered on O, with a
//                one-cycle Done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int SIGNED_EN = 1
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Start,
    input  logic               Signed,
    input  logic [WIDTH-1:0]   X,
    input  logic [WIDTH-1:0]   Y,
    output logic [2*WIDTH-1:0] O,
    output logic               Busy,
    output logic               Done
);

    // Counter must be able to reach WIDTH itself, hence the extra bit
    localparam int c_cnt_w = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;

    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mult;
    logic                 r_neg;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_o;

    logic                 w_accept;
    logic                 w_signed_mode;
    logic [WIDTH-1:0]     w_x_mag;
    logic [WIDTH-1:0]     w_y_mag;
    logic                 w_last;
    logic [WIDTH-1:0]     w_mult_sh;
    logic [2*WIDTH-1:0]   w_mcand_sh;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_sum;
    logic [2*WIDTH-1:0]   w_result;

    // A new operation may only be launched from IDLE or DONE; CALC ignores Start
    assign w_accept      = Start && ((r_state == IDLE) || (r_state == DONE));
    assign w_signed_mode = (SIGNED_EN != 0) && Signed;

    // Magnitudes: the WIDTH-bit negation of the most-negative value is
    // 2^(WIDTH-1), which is exactly the correct unsigned magnitude
    assign w_x_mag = (w_signed_mode && X[WIDTH-1]) ? (~X + {{(WIDTH-1){1'b0}}, 1'b1}) : X;
    assign w_y_mag = (w_signed_mode && Y[WIDTH-1]) ? (~Y + {{(WIDTH-1){1'b0}}, 1'b1}) : Y;

    // All WIDTH iterations are complete once the counter reaches WIDTH
    assign w_last = (r_cnt == c_last_cnt);

    // Inline shifts: select multiplier bit [counter], align multiplicand
    assign w_mult_sh  = r_mult >> r_cnt;
    assign w_mcand_sh = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
    assign w_addend   = w_mult_sh[0] ? w_mcand_sh : '0;

    add_n #(
        .WIDTH (WIDTH)
    ) u_add (
        .i_a   (r_acc),
        .i_b   (w_addend),
        .o_sum (w_sum)
    );

    // Apply the product sign to the unsigned magnitude product
    assign w_result = r_neg ? (~r_acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : r_acc;

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and status outputs
    always_comb begin
        w_next_state = r_state;
        Busy         = 1'b0;
        Done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_next_state = CALC;
                end
            end
            CALC: begin
                Busy = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                Done = 1'b1;
                if (Start) begin
                    w_next_state = CALC;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one shift-add iteration per CALC cycle
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_mcand <= '0;
            r_mult  <= '0;
            r_neg   <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (w_accept) begin
            r_mcand <= w_x_mag;
            r_mult  <= w_y_mag;
            r_neg   <= w_signed_mode && (X[WIDTH-1] ^ Y[WIDTH-1]);
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if ((r_state == CALC) && !w_last) begin
            r_acc   <= w_sum;
            r_cnt   <= r_cnt + {{(c_cnt_w-1){1'b0}}, 1'b1};
        end
    end

    // Result register, updated only on the CALC->DONE transition
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_o <= '0;
        end else if ((r_state == CALC) && w_last) begin
            r_o <= w_result;
        end
    end

    assign O = r_o;

endmodule : seq_multiplier
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_multiplier
//  Description : Self-checking bench for seq_multiplier: directed corner
//                cases plus randomized operands against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    logic        Clk = 1'b0;
    logic        Rst_n;

    // WIDTH=8, signed mode enabled
    logic        Start, Signed;
    logic [7:0]  X, Y;
    logic [15:0] O;
    logic        Busy, Done;

    // WIDTH=16, signed mode enabled
    logic        Start16, Signed16;
    logic [15:0] X16, Y16;
    logic [31:0] O16;
    logic        Busy16, Done16;

    // WIDTH=8, signed mode disabled
    logic        Startu, Signedu;
    logic [7:0]  Xu, Yu;
    logic [15:0] Ou;
    logic        Busyu, Doneu;

    int n_vec = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    seq_multiplier #(.WIDTH(8), .SIGNED_EN(1)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Signed(Signed),
        .X(X), .Y(Y), .O(O), .Busy(Busy), .Done(Done)
    );

    seq_multiplier #(.WIDTH(16), .SIGNED_EN(1)) dut16 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start16), .Signed(Signed16),
        .X(X16), .Y(Y16), .O(O16), .Busy(Busy16), .Done(Done16)
    );

    seq_multiplier #(.WIDTH(8), .SIGNED_EN(0)) dutu (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Startu), .Signed(Signedu),
        .X(Xu), .Y(Yu), .O(Ou), .Busy(Busyu), .Done(Doneu)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: integer product of the operands as interpreted, truncated to 2w bits
    function automatic logic [63:0] ref_product(input int w, input logic [31:0] x,
                                                input logic [31:0] y, input bit s);
        longint a, b, p;
        a = longint'({32'b0, x});
        b = longint'({32'b0, y});
        if (s && x[w-1]) a = a - (longint'(1) << w);
        if (s && y[w-1]) b = b - (longint'(1) << w);
        p = a * b;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic run8(input logic [7:0] x, input logic [7:0] y, input bit s, input string tag);
        logic [15:0] exp, prev;
        int n;
        exp  = 16'(ref_product(8, 32'(x), 32'(y), s));
        prev = O;
        n    = 0;
        Start = 1'b1; X = x; Y = y; Signed = s;
        tick();
        Start = 1'b0; X = 8'($urandom); Y = 8'($urandom); Signed = 1'($urandom);
        check({tag, " busy"}, 64'(Busy), 64'd1);
        while (!Done && n < 40) begin
            tick();
            n++;
            if (n == 4) check({tag, " hold"}, 64'(O), 64'(prev));
        end
        check({tag, " latency"}, 64'(n), 64'd9);
        check({tag, " O"}, 64'(O), 64'(exp));
        tick();
        check({tag, " pulse"}, 64'(Done), 64'd0);
        check({tag, " idle"}, 64'(Busy), 64'd0);
    endtask

    task automatic run16(input logic [15:0] x, input logic [15:0] y, input bit s, input string tag);
        int n;
        n = 0;
        Start16 = 1'b1; X16 = x; Y16 = y; Signed16 = s;
        tick();
        Start16 = 1'b0; X16 = 16'($urandom); Y16 = 16'($urandom);
        while (!Done16 && n < 60) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd17);
        check({tag, " O"}, 64'(O16), ref_product(16, 32'(x), 32'(y), s));
    endtask

    task automatic runu(input logic [7:0] x, input logic [7:0] y, input bit s, input string tag);
        int n;
        n = 0;
        Startu = 1'b1; Xu = x; Yu = y; Signedu = s;
        tick();
        Startu = 1'b0; Xu = 8'($urandom); Yu = 8'($urandom);
        while (!Doneu && n < 40) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd9);
        check({tag, " O"}, 64'(Ou), ref_product(8, 32'(x), 32'(y), 1'b0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int n, dones;
        logic [15:0] o_at_done;

        Rst_n = 1'b0;
        Start = 1'b0; Signed = 1'b0; X = '0; Y = '0;
        Start16 = 1'b0; Signed16 = 1'b0; X16 = '0; Y16 = '0;
        Startu = 1'b0; Signedu = 1'b0; Xu = '0; Yu = '0;
        #2;
        check("reset O", 64'(O), 64'd0);
        check("reset Busy", 64'(Busy), 64'd0);
        check("reset Done", 64'(Done), 64'd0);
        check("reset O16", 64'(O16), 64'd0);
        tick();
        tick();
        Rst_n = 1'b1;

        // Directed corners
        run8(8'hFF, 8'hFF, 1'b0, "ff*ff unsigned");
        run8(8'h80, 8'h80, 1'b1, "min*min signed");
        run8(8'hFF, 8'h7F, 1'b1, "-1*127 signed");
        run8(8'h00, 8'h80, 1'b1, "0*min signed");
        run8(8'h80, 8'h7F, 1'b1, "min*max signed");
        run8(8'h80, 8'h01, 1'b0, "128*1 unsigned");

        // Start while busy is ignored
        Start = 1'b1; X = 8'd3; Y = 8'd5; Signed = 1'b0;
        tick();
        Start = 1'b0;
        tick();
        tick();
        Start = 1'b1; X = 8'd7; Y = 8'd7;
        tick();
        Start = 1'b0;
        dones = 0;
        o_at_done = '0;
        for (int i = 0; i < 20; i++) begin
            if (Done) begin
                dones++;
                o_at_done = O;
            end
            tick();
        end
        check("ignore dones", 64'(dones), 64'd1);
        check("ignore O", 64'(o_at_done), 64'd15);

        // Back-to-back: Start accepted in the DONE cycle
        Start = 1'b1; X = 8'd4; Y = 8'd6; Signed = 1'b0;
        tick();
        Start = 1'b0;
        n = 0;
        while (!Done && n < 40) begin
            tick();
            n++;
        end
        check("b2b first O", 64'(O), 64'd24);
        Start = 1'b1; X = 8'd2; Y = 8'd9;
        tick();
        Start = 1'b0;
        check("b2b no gap", 64'(Busy), 64'd1);
        n = 0;
        while (!Done && n < 40) begin
            tick();
            n++;
        end
        check("b2b latency", 64'(n), 64'd9);
        check("b2b O", 64'(O), 64'd18);
        tick();

        // Asynchronous reset mid-CALC
        Start = 1'b1; X = 8'd5; Y = 8'd9;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        Rst_n = 1'b0;
        #1;
        check("rst O", 64'(O), 64'd0);
        check("rst Busy", 64'(Busy), 64'd0);
        check("rst Done", 64'(Done), 64'd0);
        tick();
        tick();
        Rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (Done) dones++;
            tick();
        end
        check("rst no done", 64'(dones), 64'd0);
        run8(8'd10, 8'd10, 1'b0, "after reset");

        // Randomized operands and mode
        for (int i = 0; i < 24; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), "random8");
        end

        // Wider instance
        run16(16'hFFFF, 16'hFFFF, 1'b0, "w16 ffff*ffff");
        run16(16'h8000, 16'h8000, 1'b1, "w16 min*min");
        for (int i = 0; i < 4; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom), "random16");
        end

        // Signed mode disabled: Signed input has no effect
        runu(8'hFF, 8'hFF, 1'b1, "nosign ff*ff");
        for (int i = 0; i < 4; i++) begin
            runu(8'($urandom), 8'($urandom), 1'b1, "nosign random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_seq_multiplier
`default_nettype wire

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Parameter SIGNED_EN, default 1; 1 enables the two's-complement mode, 0 ties the mode to unsigned.
REQ-003 Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Start  input  1  request: launch a multiply with the current X, Y, Signed.
REQ-006 Signed  input  1  operand mode, sampled with Start; 1 = two's-complement, 0 = unsigned.
REQ-007 X  input  WIDTH  multiplicand.
REQ-008 Y  input  WIDTH  multiplier.
REQ-009 O  output  2*WIDTH  product, registered.
REQ-010 Busy  output  1  high while an operation is in progress (CALC state).
REQ-011 Done  output  1  one-cycle pulse when O carries a new result.

Function
REQ-012 The FSM SHALL have the states IDLE, CALC and DONE.
- IDLE->CALC on Start.
- CALC->DONE after WIDTH iterations.
- DONE->CALC on Start, otherwise DONE->IDLE.
REQ-013 On accepting Start, the block SHALL capture these values into internal registers:
- |X| and |Y| when Signed=1 (and SIGNED_EN=1), otherwise raw X and Y;
- sign flag = X[MSB]^Y[MSB] in signed mode, otherwise 0;
- iteration counter = 0;
- accumulator = 0.
REQ-014 Each CALC cycle SHALL add (multiplicand << counter) to the accumulator when multiplier bit [counter] = 1, then increment the counter.
REQ-015 The counter SHALL be $clog2(WIDTH)+1 bits wide, so WIDTH=32 does not wrap before completion.
REQ-016 The accumulator and adder SHALL be 2*WIDTH bits wide; the unsigned product never overflows.
REQ-017 On entry to DONE, O SHALL be loaded with the accumulator, or with its two's-complement negation when the sign flag = 1.
REQ-018 Done SHALL be high for exactly the DONE cycle.
REQ-019 Latency: with Start sampled at edge 0, Done and the new O are visible after edge WIDTH+1.
REQ-020 Busy SHALL be 1 only in CALC; Start while Busy=1 SHALL be ignored and the in-flight operands SHALL be unaffected.
REQ-021 Start in the DONE cycle SHALL be accepted, giving back-to-back operations with no IDLE gap.
REQ-022 O SHALL hold its last value until the next DONE; X, Y and Signed may change freely after the Start cycle.
REQ-023 Signed mode: the most-negative operand (e.g. -128 at WIDTH=8) SHALL produce its magnitude 2^(WIDTH-1) correctly in the WIDTH-bit unsigned magnitude register.
REQ-024 With SIGNED_EN=0, the Signed input SHALL be ignored.

Reset
REQ-025 Rst_n=0 SHALL immediately force, independent of Clk:
- state to IDLE;
- O, Done and Busy to 0;
- counter and accumulator to 0.
REQ-026 Reset during CALC SHALL abandon the operation with no Done pulse.
REQ-027 After Rst_n rises, the first Start SHALL be accepted on the next Clk edge.

Structure
REQ-028 Shared package mult_pkg SHALL hold:
- the state encoding localparams IDLE=2'b00, CALC=2'b01, DONE=2'b10;
- default WIDTH.
REQ-029 Unused encoding 2'b11 SHALL recover to IDLE.
REQ-030 One sub-module, add_n (WIDTH-parameterised ripple/behavioural adder, 2*WIDTH bits), SHALL implement the accumulate step; the shift SHALL be inline.

Verification
REQ-031 WIDTH=8, unsigned, X=255, Y=255, Start one cycle -> after 9 edges Done=1 for one cycle, O=16'hFE01, Busy low again.
REQ-032 WIDTH=8, signed, X=8'h80, Y=8'h80 -> O=16'h4000; X=8'hFF, Y=8'h7F -> O=16'hFF81; X=0, Y=8'h80 -> O=16'h0000.
REQ-033 Start X=3, Y=5; pulse Start with X=7, Y=7 at cycle 3 -> only one Done, O=15.
REQ-034 Back-to-back: Start asserted in the DONE cycle with X=2, Y=9 -> second Done exactly 9 edges later, O=18.
REQ-035 Rst_n low at cycle 4 of CALC -> O=0, Busy=0, no Done; then a new Start with X=10, Y=10 -> O=100.
REQ-036 WIDTH=16, unsigned, X=Y=16'hFFFF -> after 17 edges O=32'hFFFE0001; SIGNED_EN=0 with Signed=1, X=Y=8'hFF -> O=16'hFE01.
